// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: packs decoded instruction fields into 20-bit words and writes them to consecutive memory addresses.
// Handshake in LOAD registers the word; WRITE pulses mem_we for one cycle. Stops on HALT or the first error.
module instruction_encoder_loader #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  start_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [3:0]  in_dr,
    input  logic [3:0]  in_sr1,
    input  logic [3:0]  in_sr2,
    input  logic [19:0] in_imm,
    input  logic [9:0]  in_addr,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [19:0] mem_wdata,
    output logic [10:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;
    state_t      r_state;
    logic [10:0] r_ptr;
    logic        r_halt;
    logic [19:0] w_word;
    logic        w_range_ok;
    logic        w_addr_ok;
    logic        w_overflow;
    assign w_addr_ok  = {1'b0, in_addr} < 11'(MEM_DEPTH);
    assign w_overflow = r_ptr >= 11'(MEM_DEPTH);
    always_comb begin
        w_word     = {in_opcode, 15'd0};
        w_range_ok = 1'b1;
        if (in_opcode >= 5'd1 && in_opcode <= 5'd9 && in_opcode[0])
            w_word[11:0] = {in_dr, in_sr1, in_sr2};
        else if (in_opcode >= 5'd2 && in_opcode <= 5'd10 && !in_opcode[0]) begin
            w_word[14:0] = {in_dr, in_sr1, in_imm[6:0]};
            w_range_ok   = (&in_imm[19:6]) || !(|in_imm[19:6]);
        end else if (in_opcode == 5'd11) begin
            w_word[13:0] = {in_dr, in_addr};
            w_range_ok   = w_addr_ok;
        end else if (in_opcode == 5'd12) begin
            w_word[13:0] = {in_sr1, in_addr};
            w_range_ok   = w_addr_ok;
        end else if (in_opcode == 5'd13)
            w_word[3:0] = in_sr1;
        else if (in_opcode == 5'd14)
            w_word[3:0] = in_dr;
        else if (in_opcode == 5'd15) begin
            w_word[9:0] = in_addr;
            w_range_ok  = w_addr_ok;
        end else if (in_opcode == 5'd16 || in_opcode == 5'd17) begin
            w_word[14:0] = {in_sr1, in_sr2, in_addr[6:0]};
            w_range_ok   = !(|in_addr[9:7]);
        end
    end
    // ptr and word_count advance on the handshake edge, so they already show the new values during the write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_halt     <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (w_overflow || in_opcode > 5'd17 || !w_range_ok) begin
                            r_state  <= ERR;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= w_overflow ? 2'd3 : (in_opcode > 5'd17) ? 2'd1 : 2'd2;
                        end else begin
                            r_state    <= WRITE;
                            mem_we     <= 1'b1;
                            mem_addr   <= r_ptr[9:0];
                            mem_wdata  <= w_word;
                            r_ptr      <= r_ptr + 11'd1;
                            word_count <= word_count + 11'd1;
                            r_halt     <= in_opcode == 5'd0;
                        end
                    end
                end
                WRITE: begin
                    mem_we   <= 1'b0;
                    r_state  <= r_halt ? DONE : LOAD;
                    in_ready <= !r_halt;
                    busy     <= !r_halt;
                    done     <= r_halt;
                end
                default: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_ptr      <= {1'b0, start_addr};
                        word_count <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        err_code   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb_instruction_encoder_loader: directed bench with a write scoreboard for a full-depth and a 4-word loader.
module tb_instruction_encoder_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start4 = 1'b0;
    logic [9:0]  start_addr = '0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic [4:0]  in_opcode = '0;
    logic [3:0]  in_dr = '0, in_sr1 = '0, in_sr2 = '0;
    logic [19:0] in_imm = '0;
    logic [9:0]  in_addr = '0;
    logic        in_ready, mem_we, busy, done, err;
    logic [9:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic [10:0] word_count;
    logic [1:0]  err_code;
    logic        in_ready4, mem_we4, busy4, done4, err4;
    logic [9:0]  mem_addr4;
    logic [19:0] mem_wdata4;
    logic [10:0] word_count4;
    logic [1:0]  err_code4;
    int n_tests = 0, n_fail = 0;
    logic [29:0] q[$], q4[$];

    always #5 clk = ~clk;

    instruction_encoder_loader dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_dr(in_dr), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_imm(in_imm), .in_addr(in_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    instruction_encoder_loader #(.MEM_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .start_addr(start_addr),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_opcode(in_opcode),
        .in_dr(in_dr), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_imm(in_imm), .in_addr(in_addr),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .word_count(word_count4),
        .busy(busy4), .done(done4), .err(err4), .err_code(err_code4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (q.size() == 0) check("unexpected_write", {12'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else check("sb_write", {2'd0, mem_addr, mem_wdata}, {2'd0, q.pop_front()});
        end
        if (mem_we4) begin
            if (q4.size() == 0) check("unexpected_write4", {12'd0, mem_addr4, mem_wdata4}, 32'hFFFF_FFFF);
            else check("sb_write4", {2'd0, mem_addr4, mem_wdata4}, {2'd0, q4.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session(input bit sel, input logic [9:0] a);
        start_addr = a;
        if (sel) start4 = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0;
        start4 = 1'b0;
    endtask

    // Returns just after the handshake edge; expected write is queued when the bundle is driven.
    task automatic send(input bit sel, input logic [4:0] op, input logic [3:0] dr, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [19:0] imm, input logic [9:0] ad,
                        input bit exp_w, input logic [9:0] ea, input logic [19:0] ed);
        int k;
        in_opcode = op; in_dr = dr; in_sr1 = s1; in_sr2 = s2; in_imm = imm; in_addr = ad;
        if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
        k = 0;
        while (!(sel ? in_ready4 : in_ready) && k < 20) begin
            tick();
            k++;
        end
        check("hs_ready", {31'd0, sel ? in_ready4 : in_ready}, 32'd1);
        if (exp_w) begin
            if (sel) q4.push_back({ea, ed}); else q.push_back({ea, ed});
        end
        tick();
        in_valid = 1'b0;
        in_valid4 = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_we", {31'd0, mem_we}, 0);
        check("rst_flags", {busy, done, err, err_code}, 0);
        check("rst_addr_data", {2'd0, mem_addr, mem_wdata}, 0);
        check("rst_wc", {21'd0, word_count}, 0);
        check("rst4_flags", {in_ready4, mem_we4, busy4, done4, err4, err_code4}, 0);
        rst = 1'b0;
        tick();
        begin_session(0, 10'h010);
        check("load_ready_busy", {in_ready, busy}, 2'b11);
        send(0, 5'd1, 4'd3, 4'd5, 4'd9, 20'd0, 10'd0, 1, 10'h010, 20'h08359);
        check("wr_we", {31'd0, mem_we}, 1);
        check("wr_addr", {22'd0, mem_addr}, 32'h010);
        check("wr_data", {12'd0, mem_wdata}, 32'h08359);
        check("wr_wc", {21'd0, word_count}, 1);
        check("wr_ready_low", {31'd0, in_ready}, 0);
        tick();
        check("ready_back", {in_ready, mem_we}, 2'b10);
        send(0, 5'd2, 4'd4, 4'd2, 4'd0, 20'hFFFFD, 10'd0, 1, 10'h011, 20'h1217D);
        tick();
        send(0, 5'd11, 4'd7, 4'd0, 4'd0, 20'd0, 10'h155, 1, 10'h012, 20'h59D55);
        tick();
        start_addr = 10'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_load_ignored", {30'd0, in_ready, busy}, 2'b11);
        send(0, 5'd13, 4'd0, 4'd6, 4'd0, 20'd0, 10'd0, 1, 10'h013, 20'h68006);
        check("ptr_unchanged", {22'd0, mem_addr}, 32'h013);
        tick();
        send(0, 5'd14, 4'd5, 4'd0, 4'd0, 20'd0, 10'd0, 1, 10'h014, 20'h70005);
        tick();
        send(0, 5'd15, 4'd0, 4'd0, 4'd0, 20'd0, 10'h3FF, 1, 10'h015, 20'h783FF);
        tick();
        send(0, 5'd12, 4'd0, 4'd9, 4'd0, 20'd0, 10'h02A, 1, 10'h016, 20'h6242A);
        tick();
        check("wc_session1", {21'd0, word_count}, 7);
        begin_session(0, 10'h100);
        check("wc_ignored_start", {21'd0, word_count}, 7);
        send(0, 5'd0, 4'd0, 4'd0, 4'd0, 20'd0, 10'd0, 1, 10'h017, 20'h00000);
        tick();
        check("halt1_done", {done, busy}, 2'b10);
        begin_session(0, 10'h100);
        check("restart_clear", {done, busy, err, word_count}, {3'b010, 11'd0});
        send(0, 5'd16, 4'd0, 4'd10, 4'd6, 20'd0, 10'h045, 1, 10'h100, 20'h85345);
        tick();
        send(0, 5'd0, 4'd7, 4'd7, 4'd7, 20'hFFFFF, 10'h3FF, 1, 10'h101, 20'h00000);
        tick();
        check("halt_done_busy", {done, busy, in_ready, err}, 4'b1000);
        check("halt_wc", {21'd0, word_count}, 2);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check("done_holds", {done, busy, word_count}, {2'b10, 11'd2});
        begin_session(0, 10'h000);
        send(0, 5'd20, 4'd0, 4'd0, 4'd0, 20'd0, 10'd0, 0, 10'd0, 20'd0);
        check("badop_err", {29'd0, err, err_code}, {29'd0, 3'b101});
        check("badop_nowe", {mem_we, busy, done, word_count}, 0);
        begin_session(0, 10'h000);
        send(0, 5'd2, 4'd1, 4'd1, 4'd0, 20'd64, 10'd0, 0, 10'd0, 20'd0);
        check("imm64_err", {29'd0, err, err_code}, {29'd0, 3'b110});
        begin_session(0, 10'h000);
        send(0, 5'd2, 4'd1, 4'd1, 4'd0, 20'hFFFBF, 10'd0, 0, 10'd0, 20'd0);
        check("immm65_err", {29'd0, err, err_code}, {29'd0, 3'b110});
        begin_session(0, 10'h000);
        send(0, 5'd2, 4'd1, 4'd1, 4'd0, 20'hFFFC0, 10'd0, 1, 10'h000, 20'h108C0);
        tick();
        check("immm64_ok", {err, busy}, 2'b01);
        send(0, 5'd17, 4'd0, 4'd1, 4'd2, 20'd0, 10'd200, 0, 10'd0, 20'd0);
        check("br200_err", {29'd0, err, err_code}, {29'd0, 3'b110});
        check("br200_wc", {21'd0, word_count}, 1);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("err_holds", {err, err_code, busy}, 4'b1100);
        begin_session(0, 10'h050);
        send(0, 5'd1, 4'd1, 4'd2, 4'd3, 20'd0, 10'd0, 0, 10'd0, 20'd0);
        check("pre_rst_we", {31'd0, mem_we}, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_write", {in_ready, mem_we, busy, done, err, err_code}, 0);
        check("rst_mid_regs", {1'b0, mem_addr, mem_wdata, word_count}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_idle_ignores_valid", {in_ready, busy}, 0);
        begin_session(1, 10'd2);
        send(1, 5'd1, 4'd1, 4'd2, 4'd3, 20'd0, 10'd0, 1, 10'd2, 20'h08123);
        tick();
        send(1, 5'd1, 4'd1, 4'd2, 4'd3, 20'd0, 10'd0, 1, 10'd3, 20'h08123);
        tick();
        send(1, 5'd1, 4'd1, 4'd2, 4'd3, 20'd0, 10'd0, 0, 10'd0, 20'd0);
        check("ovf_err", {29'd0, err4, err_code4}, {29'd0, 3'b111});
        check("ovf_wc", {21'd0, word_count4}, 2);
        begin_session(1, 10'd2);
        send(1, 5'd1, 4'd1, 4'd2, 4'd3, 20'd0, 10'd0, 1, 10'd2, 20'h08123);
        tick();
        send(1, 5'd0, 4'd0, 4'd0, 4'd0, 20'd0, 10'd0, 1, 10'd3, 20'h00000);
        tick();
        check("halt_last_done", {done4, err4, busy4}, 3'b100);
        check("halt_last_addr", {22'd0, mem_addr4}, 3);
        begin_session(1, 10'd0);
        send(1, 5'd11, 4'd1, 4'd0, 4'd0, 20'd0, 10'd4, 0, 10'd0, 20'd0);
        check("ld_addr_range", {29'd0, err4, err_code4}, {29'd0, 3'b110});
        tick();
        tick();
        check("sb_empty", q.size(), 0);
        check("sb4_empty", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
Sequential inverse of the instruction decoder. It accepts decoded instruction fields over a valid/ready handshake, packs them into 20-bit instruction words in the core ISA format, and writes them to consecutive instruction-memory addresses. It sits between the test/boot program source and the instruction memory write port. It range-checks every field, stops on HALT, and latches the first error.

Parameters:
MEM_DEPTH, 1024, number of writable instruction words; legal write addresses are 0..MEM_DEPTH-1 (MEM_DEPTH <= 1024).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; loads start_addr and begins a load session (honoured only in IDLE, DONE or ERR)
start_addr  input  10  first memory address of the session
in_valid  input  1  field bundle valid
in_ready  output  1  loader can accept a bundle
in_opcode  input  5  opcode 0..17
in_dr  input  4  destination register
in_sr1  input  4  source register 1
in_sr2  input  4  source register 2
in_imm  input  20  signed immediate (two's complement)
in_addr  input  10  memory or branch address
mem_we  output  1  instruction memory write strobe
mem_addr  output  10  write address
mem_wdata  output  20  encoded instruction word
word_count  output  11  words written this session
busy  output  1  state is LOAD or WRITE
done  output  1  HALT written, session closed
err  output  1  session aborted
err_code  output  2  1 = illegal opcode, 2 = field out of range, 3 = memory overflow

Behaviour:
- Reset (async) values: state IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr, mem_wdata, err_code = 0; word_count = 0; internal pointer ptr (11 bit) = 0.
- States:
  - IDLE: on start go to LOAD; set ptr = start_addr; clear word_count, done, err and err_code.
  - LOAD: in_ready = 1. A handshake (in_valid & in_ready) runs the checks below in this priority order:
    - if ptr >= MEM_DEPTH: go to ERR, err_code 3;
    - else if in_opcode > 17: go to ERR, err_code 1;
    - else if the field range check fails: go to ERR, err_code 2;
    - else register the encoded word and go to WRITE.
  - WRITE: mem_we = 1 for exactly one cycle with mem_addr = ptr[9:0] and mem_wdata = the encoded word. In the same cycle word_count and ptr increment. Next state is DONE if the opcode was 0, otherwise LOAD.
  - DONE: done = 1. ERR: err = 1. Both states hold until start or rst; start restarts exactly as from IDLE.
- Timing: the handshake occurs in cycle N and the write happens in cycle N+1. in_ready is 0 in WRITE, so maximum throughput is one word per 2 cycles. mem_we is never asserted outside WRITE.
- start asserted in LOAD or WRITE is ignored. An in_valid in a state other than LOAD is not consumed.
- Encoding: opcode goes in [19:15]. Every bit not listed below is 0, and unused input fields are ignored.
  - 0 HALT: all other bits 0.
  - Odd 1,3,5,7,9 (register ALU): dr [11:8], sr1 [7:4], sr2 [3:0].
  - Even 2,4,6,8,10 (immediate ALU): dr [14:11], sr1 [10:7], imm[6:0] in [6:0].
  - 11 LD: dr [13:10], addr [9:0].
  - 12 ST: sr1 [13:10], addr [9:0].
  - 13 PUSH: sr1 [3:0].
  - 14 POP: dr [3:0].
  - 15 JUMP: addr [9:0].
  - 16/17 branch: sr1 [14:11], sr2 [10:7], addr[6:0] in [6:0].
- Range checks:
  - Immediate ALU: in_imm must lie in -64..63, i.e. bits [19:6] all equal.
  - Branch: in_addr must be <= 127.
  - LD, ST, JUMP: in_addr must be < MEM_DEPTH.
- Overflow: after the word at MEM_DEPTH-1 is written, ptr = MEM_DEPTH. The next handshake gives err_code 3 and nothing is written. A HALT written at MEM_DEPTH-1 completes normally.
- An error aborts the session with no write for the failing bundle. Words already written remain in memory.
- rst asserted mid-WRITE: the write is dropped and all outputs take their reset values immediately.

Test Plan:
- rst, start with start_addr=0x010, then opcode 1, dr=3, sr1=5, sr2=9 -> one cycle after the handshake: mem_we=1, mem_addr=0x010, mem_wdata=0x08359; word_count=1; in_ready low for exactly 1 cycle.
- Opcode 2, dr=4, sr1=2, imm=-3 (0xFFFFD), then opcode 11, dr=7, addr=0x155 -> writes 0x1217D, then 0x59D55 at consecutive addresses.
- Opcode 16, sr1=10, sr2=6, addr=0x45, then opcode 0 -> writes 0x85345, then 0x00000. done=1, busy=0, word_count=2, in_ready=0 afterwards.
- Illegal inputs:
  - opcode 20 -> err=1, err_code=1, no mem_we;
  - restart, then opcode 2 with imm=64 -> err_code=2;
  - restart, then opcode 17 with addr=200 -> err_code=2.
- MEM_DEPTH=4, start_addr=2: push 3 non-HALT bundles -> writes at 2 and 3, the third handshake gives err_code=3, word_count=2. Repeat with a HALT as the second bundle -> done at address 3.
- Assert rst during WRITE -> mem_we drops the same cycle, all outputs take reset values. start during LOAD is ignored and ptr is unchanged.
